// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the board-side debug/stepping logic
// in front of the single-cycle MIPS core.
package mips_dbg_pkg;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RUN  = 1'b1
    } step_mode_e;

    localparam int STEP_CNT_W          = 16;
    localparam int RATE_W              = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_RUN_DIV         = 1048576;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low key;
// emits a one-cycle press strobe on each debounced 1->0 transition.
module key_debounce
    import mips_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic key_db,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            key_db <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == key_db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // accept the new level; only the falling edge is an event
                key_db <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mips_step_ctrl.sv
// Step/run controller: turns debounced keys into single-cycle clock
// enables for the core, with a rate-selectable free-run prescaler.
module mips_step_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = DEF_RUN_DIV
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  key_step_n,
    input  logic                  key_run_n,
    input  logic [RATE_W-1:0]     sw_rate,
    output logic                  step_pulse,
    output logic                  run_mode,
    output logic [STEP_CNT_W-1:0] step_count,
    output logic                  key_step_db,
    output logic                  key_run_db
);

    // wide enough for RUN_DIV shifted by the largest rate select
    localparam int PW = $clog2(RUN_DIV) + (1 << RATE_W) + 1;

    step_mode_e    state;
    step_mode_e    state_d;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_d;
    logic [PW-1:0] period;
    logic          pulse_d;
    logic          step_press;
    logic          run_press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_step (
        .clk    (clk),
        .reset_n(reset_n),
        .key_n  (key_step_n),
        .key_db (key_step_db),
        .press  (step_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_run (
        .clk    (clk),
        .reset_n(reset_n),
        .key_n  (key_run_n),
        .key_db (key_run_db),
        .press  (run_press)
    );

    always_comb begin
        period  = PW'(RUN_DIV) << sw_rate;
        state_d = state;
        presc_d = '0;
        pulse_d = 1'b0;
        unique case (state)
            MODE_STEP: begin
                // a mode toggle swallows a coincident step press
                if (run_press) state_d = MODE_RUN;
                else           pulse_d = step_press;
            end
            MODE_RUN: begin
                if (run_press) begin
                    state_d = MODE_STEP;
                end else if (presc >= period - PW'(1)) begin
                    pulse_d = 1'b1;
                end else begin
                    presc_d = presc + PW'(1);
                end
            end
            default: state_d = MODE_STEP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= MODE_STEP;
            presc      <= '0;
            step_pulse <= 1'b0;
            run_mode   <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_d;
            presc      <= presc_d;
            step_pulse <= pulse_d;
            run_mode   <= (state_d == MODE_RUN);
            step_count <= step_count + STEP_CNT_W'(pulse_d);
        end
    end

endmodule
